// File: rtl/rotate_right_iter.sv
// Iterative 16-bit right rotate / logical / arithmetic shifter.
// One log-shifter stage per clock, fixed four-cycle latency.
module rotate_right_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] In,
    input  logic [3:0]  Cnt,
    input  logic [1:0]  Op,
    output logic [15:0] Out,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] w_q, w_d;
    logic [3:0]  c_q, c_d;
    logic [1:0]  p_q, p_d;
    logic [1:0]  s_q, s_d;
    logic [15:0] out_q, out_d;

    logic [3:0]  amt;
    logic [31:0] rot_wide;
    logic [15:0] srl_res;
    logic [15:0] sra_res;
    logic [15:0] stage_res;

    // Stage S moves W by 2^S when bit S of the amount is set.
    always_comb begin
        amt       = 4'd1 << s_q;
        rot_wide  = {w_q, w_q} >> amt;
        srl_res   = w_q >> amt;
        sra_res   = $signed(w_q) >>> amt;
        stage_res = w_q;
        if (c_q[s_q]) begin
            unique case (p_q)
                2'b01:   stage_res = srl_res;
                2'b10:   stage_res = sra_res;
                default: stage_res = rot_wide[15:0];
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        c_d     = c_q;
        p_d     = p_q;
        s_d     = s_q;
        out_d   = out_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    w_d     = In;
                    c_d     = Cnt;
                    p_d     = Op;
                    s_d     = 2'd0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                w_d = stage_res;
                s_d = s_q + 2'd1;
                if (s_q == 2'd3) begin
                    out_d   = stage_res;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            w_q     <= 16'h0000;
            c_q     <= 4'd0;
            p_q     <= 2'd0;
            s_q     <= 2'd0;
            out_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            c_q     <= c_d;
            p_q     <= p_d;
            s_q     <= s_d;
            out_q   <= out_d;
        end
    end

    assign Out  = out_q;
    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);

endmodule

// File: doc/rotate_right_iter.md
ROTATE_RIGHT_ITER -- requirements
Module: rotate_right_iter

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 start  input  1  request; sampled on rising clk edge; accepted only in IDLE or DONE.
REQ-004 In  input  16  operand; captured on the accepting edge.
REQ-005 Cnt  input  4  shift/rotate amount 0-15; captured on the accepting edge.
REQ-006 Op  input  2  00 rotate right, 01 shift right logical, 10 shift right arithmetic, 11 rotate right; captured on the accepting edge.
REQ-007 Out  output  16  registered result; holds its value until the next completion.
REQ-008 busy  output  1  high while in SHIFT.
REQ-009 done  output  1  high exactly one cycle when Out is updated.

Function
REQ-010 FSM states SHALL be IDLE, SHIFT, DONE, encoded in registered state bits.
REQ-011 IDLE: start=1 SHALL capture In into working register W, Cnt into C, Op into P, clear 2-bit stage counter S, go to SHIFT; start=0 stays IDLE.
REQ-012 SHIFT: each edge SHALL apply stage S to W: if C[S]=1, move W right by 2^S positions, else keep W; then S increments.
REQ-013 Vacated MSBs per stage SHALL be: rotate, the bits shifted out of the LSB end; SRL, 0; SRA, copies of W[15] at the time the stage is applied.
REQ-014 On the edge applying stage 3, the stage-3 result SHALL be loaded into Out and state SHALL go to DONE.
REQ-015 Latency SHALL be fixed: accepting edge N, Out valid and done=1 in the cycle after edge N+4, independent of Cnt (including Cnt=0).
REQ-016 DONE SHALL last one cycle; start=1 in DONE SHALL be accepted as in IDLE (back-to-back, next done at edge N+5 after previous done edge); otherwise go to IDLE.
REQ-017 start during SHIFT SHALL be ignored, with no effect on W, C, P or S.
REQ-018 Inputs In/Cnt/Op changing after the accepting edge SHALL NOT affect the result in progress.
REQ-019 busy SHALL equal (state==SHIFT); done SHALL equal (state==DONE); both decoded from registered state only.
REQ-020 Result SHALL equal the single-step operation: ROR, (In>>Cnt)|(In<<(16-Cnt)); SRL, In>>Cnt; SRA, sign-filled In>>Cnt; Cnt=0 returns In.

Reset
REQ-021 rst=1 SHALL immediately, without clk, force state IDLE, Out=16'h0000, W=0, C=0, P=0, S=0, busy=0, done=0.
REQ-022 rst asserted mid-SHIFT or in DONE SHALL abort the operation; no done pulse SHALL follow deassertion.
REQ-023 After rst deasserts, the first accepting edge SHALL be the first rising edge with start=1 and rst=0.

Verification
REQ-024 Op=00, In=16'h8001, Cnt=1 -> Out=16'hC000, done one cycle after edge N+4, busy high for 4 cycles.
REQ-025 Op=00, In=16'h1234, Cnt=4 -> Out=16'h4123; then Op=00, In=16'hABCD, Cnt=0 -> Out=16'hABCD with the same 4-cycle latency.
REQ-026 Op=01, In=16'h8000, Cnt=15 -> Out=16'h0001; Op=10, In=16'h8000, Cnt=15 -> Out=16'hFFFF; Op=10, In=16'h4000, Cnt=14 -> Out=16'h0001.
REQ-027 start held high continuously with new operands each DONE cycle -> done pulses every 5 cycles, each Out matching its captured operands; starts during SHIFT ignored.
REQ-028 rst pulsed during SHIFT stage 2 (asynchronous to clk) -> Out=16'h0000, busy=0, done=0 immediately, no later done pulse; next start completes normally.
REQ-029 In/Cnt/Op toggled randomly every cycle during SHIFT -> result matches operands captured at the accepting edge; random regression compared against the REQ-020 reference model.
